// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, ALU control and halt-state definitions for decode_stage
package decode_pkg;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_BR    = 4'h2;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_PIX   = 4'h5;
    localparam logic [3:0] OP_WR6   = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_LD    = 4'h8;
    localparam logic [3:0] OP_ALU_R = 4'hA;
    localparam logic [3:0] OP_ALU_X = 4'hB;
    localparam logic [3:0] OP_IMM0  = 4'hC;
    localparam logic [3:0] OP_IMM1  = 4'hD;
    localparam logic [3:0] OP_IMM2  = 4'hE;
    localparam logic [3:0] OP_IMM3  = 4'hF;

    localparam logic [3:0] ALU_IMM0   = 4'h0;
    localparam logic [3:0] ALU_IMM1   = 4'h1;
    localparam logic [3:0] ALU_IMM2   = 4'h2;
    localparam logic [3:0] ALU_IMM3   = 4'h3;
    localparam logic [3:0] ALU_X_ZERO = 4'h8;
    localparam logic [3:0] ALU_NOP    = 4'hF;

    typedef enum logic {ST_RUN, ST_HALTED} halt_state_e;

    // Control bundle carried across the ID/EX boundary
    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       rqrd_imm;
        logic       rs_imm;
        logic       mem_read;
        logic       mem_write;
        logic       write_en;
        logic       pixel_en;
        logic       pixel_value;
        logic [3:0] alu_ctrl;
        logic [2:0] wreg;
    } ctrl_t;

    function automatic logic [3:0] alu_ctrl_of(input logic [15:0] inst);
        logic [3:0] ctrl;
        case (inst[15:12])
            OP_IMM0:  ctrl = ALU_IMM0;
            OP_IMM1:  ctrl = ALU_IMM1;
            OP_IMM2:  ctrl = ALU_IMM2;
            OP_IMM3:  ctrl = ALU_IMM3;
            OP_ALU_X: ctrl = (inst[2:0] != 3'd0) ? {1'b0, inst[2:0]} : ALU_X_ZERO;
            OP_ALU_R: ctrl = {1'b1, inst[2:0]};
            default:  ctrl = ALU_NOP;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/decode_stage_reg_bank.sv
// rtl/decode_stage_reg_bank.sv - 8-entry register bank, two async reads, optional write-through
module reg_bank #(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        raddr1_i,
    input  logic [2:0]        raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [8];

    // Synchronous write port; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Async reads, forwarding a same-cycle write when bypass is enabled
    always_comb begin
        rdata1_o = mem_q[raddr1_i];
        rdata2_o = mem_q[raddr2_i];
        if (BYPASS != 0 && we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (BYPASS != 0 && we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - pipelined decode with load-use interlock, flush and halt control
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 16,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_pc_plus1,
    input  logic [15:0]       in_inst,
    input  logic              flush,
    input  logic              resume,
    input  logic              wb_en,
    input  logic [2:0]        wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       out_inst,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [2:0]        out_wreg,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_rqrd_imm,
    output logic              out_rs_imm,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_write_en,
    output logic              out_pixel_en,
    output logic              out_pixel_value,
    output logic [3:0]        out_alu_ctrl,
    output logic              halted,
    output logic [15:0]       stall_count
);

    logic [3:0]        opcode;
    logic [2:0]        rs1, rs2;
    logic              is_halt, is_load, is_store;
    ctrl_t             dec;
    logic [DATA_W-1:0] rd1, rd2;
    logic              hazard, advance, accept;

    halt_state_e       state_q, state_d;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       inst_q, inst_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [15:0]       stall_q, stall_d;

    assign opcode = in_inst[15:12];

    // Control-field decode of the instruction offered by fetch
    always_comb begin
        is_halt         = (opcode == OP_HALT);
        is_load         = (opcode == OP_LD);
        is_store        = (opcode == OP_ST);
        rs1             = in_inst[14] ? in_inst[11:9] : in_inst[5:3];
        rs2             = in_inst[8:6];
        dec             = '0;
        dec.branch      = (opcode == OP_BR);
        dec.jump        = (opcode == OP_JMP);
        dec.pixel_en    = (opcode == OP_PIX);
        dec.pixel_value = in_inst[0];
        dec.mem_write   = is_store;
        dec.mem_read    = is_load;
        dec.rqrd_imm    = is_load | is_store;
        dec.rs_imm      = in_inst[15] & in_inst[14];
        dec.write_en    = in_inst[15] | (opcode == OP_WR6);
        dec.wreg        = in_inst[11:9];
        dec.alu_ctrl    = alu_ctrl_of(in_inst);
    end

    reg_bank #(.DATA_W(DATA_W), .BYPASS(BYPASS)) u_reg_bank (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_en),
        .waddr_i  (wb_reg),
        .wdata_i  (wb_data),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Load-use interlock, handshake and next-state for FSM, ID/EX and stall counter
    always_comb begin
        hazard   = valid_q & ctrl_q.mem_read & ctrl_q.write_en & in_valid &
                   ((ctrl_q.wreg == rs1) | ((ctrl_q.wreg == rs2) & ~dec.rs_imm));
        advance  = ~valid_q | out_ready;
        in_ready = ~rst & (state_q == ST_RUN) & ~hazard & ~flush & advance;
        accept   = in_valid & in_ready;

        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept && is_halt) state_d = ST_HALTED;
            ST_HALTED: if (resume) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        valid_d  = valid_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        ctrl_d   = ctrl_q;
        if (accept) begin
            valid_d  = 1'b1;
            pc_d     = in_pc;
            inst_d   = in_inst;
            rdata1_d = rd1;
            rdata2_d = rd2;
            ctrl_d   = dec;
        end else if (flush || advance) begin
            valid_d = 1'b0;
        end

        stall_d = (hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            ctrl_q   <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            ctrl_q   <= ctrl_d;
            stall_q  <= stall_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_inst        = inst_q;
    assign out_rdata1      = rdata1_q;
    assign out_rdata2      = rdata2_q;
    assign out_wreg        = ctrl_q.wreg;
    assign out_branch      = ctrl_q.branch;
    assign out_jump        = ctrl_q.jump;
    assign out_rqrd_imm    = ctrl_q.rqrd_imm;
    assign out_rs_imm      = ctrl_q.rs_imm;
    assign out_mem_read    = ctrl_q.mem_read;
    assign out_mem_write   = ctrl_q.mem_write;
    assign out_write_en    = ctrl_q.write_en;
    assign out_pixel_en    = ctrl_q.pixel_en;
    assign out_pixel_value = ctrl_q.pixel_value;
    assign out_alu_ctrl    = ctrl_q.alu_ctrl;
    assign halted          = (state_q == ST_HALTED);
    assign stall_count     = stall_q;

    logic unused_ok;
    assign unused_ok = ^in_pc_plus1;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined successor to the combinational decode logic of the 16-bit CPU. It accepts instructions from fetch over a valid/ready handshake and decodes control fields. It reads an internal register bank with an optional write-through bypass from writeback. Results are held in a registered ID/EX boundary. It adds three things: load-use hazard interlock with bubble insertion, branch flush, and a halt state machine with optional resume. It sits between fetch and execute.

## Interface
- `DATA_W`, default 32: register and write-back data width.
- `PC_W`, default 16: program-counter width.
- `BYPASS`, default 1: when 1, a writeback to the register being read in the same cycle returns the new data.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1 / `in_ready`, out, 1: fetch handshake.
- `in_pc`, in, `PC_W` / `in_pc_plus1`, in, `PC_W` / `in_inst`, in, 16: fetched instruction and its PCs.
- `flush`, in, 1: branch/jump taken in execute; kill the decode contents.
- `resume`, in, 1: leave the halted state.
- `wb_en`, in, 1 / `wb_reg`, in, 3 / `wb_data`, in, `DATA_W`: writeback port.
- `out_valid`, out, 1 / `out_ready`, in, 1: ID/EX handshake.
- `out_pc`, out, `PC_W` / `out_inst`, out, 16 / `out_rdata1`, out, `DATA_W` / `out_rdata2`, out, `DATA_W` / `out_wreg`, out, 3: registered decode payload.
- Registered control bits, each out, 1:
  - `out_branch`, `out_jump`, `out_rqrd_imm`, `out_rs_imm`
  - `out_mem_read`, `out_mem_write`, `out_write_en`, `out_pixel_en`, `out_pixel_value`
- `out_alu_ctrl`, out, 4: registered ALU control.
- `halted`, out, 1: halt state machine is in HALTED.
- `stall_count`, out, 16: saturating count of hazard-stall cycles.

## Operation
- Opcode is `inst[15:12]`.
- Control decode per opcode:
  - halt = 0000.
  - branch = 0010.
  - jump = 0100.
  - pixel = 0101, with `pixel_value` = `inst[0]`.
  - store = 0111.
  - load = 1000.
  - `rqrd_imm` = load | store.
  - `rs_imm` = `inst[15] & inst[14]`.
  - `write_en` = `inst[15]` | (opcode == 0110).
  - `wreg` = `inst[11:9]`.
- Source registers:
  - rs1 = `inst[14]` ? `inst[11:9]` : `inst[5:3]`.
  - rs2 = `inst[8:6]`.
- ALU control:
  - 1100→0, 1101→1, 1110→2, 1111→3.
  - 1011 → {0, `inst[2:0]`} when `inst[2:0]` ≠ 0, else 8.
  - 1010 → {1, `inst[2:0]`}.
  - otherwise 15.
- Register bank: 8 × `DATA_W`, two asynchronous read ports, one synchronous write port.
- Hazard: asserted when all of the following hold:
  - `out_valid` & `out_mem_read` & `out_write_en`
  - `in_valid`
  - `out_wreg` == rs1, or (`out_wreg` == rs2 & !`rs_imm`).
- Ready: `in_ready` = !`halted` & !hazard & !`flush` & (!`out_valid` | `out_ready`).
- Register advance: ID/EX updates when !`out_valid` | `out_ready`.
  - Loads the decoded instruction if accepted.
  - Otherwise loads a bubble: `out_valid`=0, payload unchanged.
- `flush`: `out_valid` ← 0 next cycle regardless of `out_ready`. The fetch transaction in that cycle is not accepted.
- Halt state machine, states RUN and HALTED:
  - RUN→HALTED when a halt instruction is accepted. The halt itself is passed to ID/EX with `out_valid`=1.
  - HALTED→RUN on `resume`. No transition on `flush`.
  - In HALTED: `in_ready`=0, and `out_valid` clears after the pending item drains.
- `stall_count` increments each cycle hazard & `in_valid` is high. It saturates at 0xFFFF.

## Timing
- Accept-to-`out_valid` latency: 1 cycle.
- A load-use pair costs exactly one bubble cycle when `out_ready`=1.
- Write-then-read in the same cycle:
  - `BYPASS`=1: read returns `wb_data`.
  - `BYPASS`=0: read returns the old value; the new value is visible next cycle.
- Simultaneous `flush` and hazard: flush wins; `stall_count` still increments.
- Simultaneous `resume` and `rst`: rst wins.
- Reset values: all out payload and control fields 0, `out_valid`=0, state RUN (`halted`=0), `stall_count`=0, register bank 0.
- `in_ready` is held 0 during reset.
- Reset mid-stall or mid-halt returns to RUN with an empty ID/EX next cycle.

## Structure
- Package `decode_pkg`:
  - opcode constants (OP_HALT, OP_BR, OP_JMP, OP_PIX, OP_WR6, OP_ST, OP_LD, OP_ALU_R, OP_ALU_X, OP_IMM0–3)
  - ALU control constants, including ALU_NOP = 4'hF
  - halt state enum {ST_RUN, ST_HALTED}
- Sub-module `reg_bank`: 8-entry register bank, parametrised by `DATA_W` and `BYPASS`.
- Decode, hazard, state machine and ID/EX register live in the top module.

## Test plan
- Reset, then accept `C248` (opcode 1100, rd=1, rs=1) with `out_ready`=1:
  - next cycle `out_valid`=1, `out_alu_ctrl`=0, `out_rs_imm`=1, `out_write_en`=1, `out_wreg`=1.
- Load r2 (`8400`), then `A083` (rs1=r0, rs2=r2):
  - one bubble (`out_valid`=0) and `in_ready`=0 for one cycle.
  - `stall_count`=1.
  - ALU op then issues with `out_alu_ctrl`=4'hB.
- Writeback r3 = 0xDEADBEEF in the same cycle as decoding an instruction with rs2=r3:
  - `out_rdata2`=0xDEADBEEF when `BYPASS`=1.
  - `out_rdata2`=0 when `BYPASS`=0.
- Halt `0000` accepted:
  - `halted`=1 next cycle, `in_ready`=0 with `in_valid` held.
  - `resume` pulse gives `halted`=0 and acceptance resumes the following cycle.
- `out_ready`=0 with valid ID/EX and new input:
  - `in_ready`=0, payload stable.
  - asserting `flush` clears `out_valid` next cycle.
- Hold a load-use hazard for 70000 cycles:
  - `stall_count` saturates at 0xFFFF.
  - `rst` returns all outputs to 0.
